// File: rtl/carry_select_adder_tt.sv
// carry_select_adder_tt
//   4-bit carry-select adder in the standard tile harness.
//   The low 2 bits ripple from cin. The high 2 bits are computed twice, once
//   assuming carry-in 0 and once assuming carry-in 1. The low-block carry then
//   picks one of the two results. The sum and flags are registered on uo_out.
// Ports
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset (clears uo_out)
//   ena     : update enable for the output register
//   ui_in   : [3:0]=A, [7:4]=B
//   uio_in  : [0]=cin, [7:1] unused
//   uo_out  : [3:0]=S, [4]=cout, [5]=V, [6]=Z, [7]=C2
//   uio_out : constant 0
//   uio_oe  : constant 0 (all bidirectional pins are inputs)

// One-bit full adder, the per-bit cell of every ripple block.
module csa_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// W-bit ripple adder built as an array of full-adder cells.
module csa_rca #(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;
  assign c[0] = ci;

  csa_fa u_fa [W-1:0] (
    .a  (a),
    .b  (b),
    .ci (c[W-1:0]),
    .s  (s),
    .co (c[W:1])
  );

  assign co = c[W];
endmodule

module carry_select_adder_tt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int NUM_SPEC = 2;  // speculative high blocks: carry-in 0 and 1

  logic [3:0] a, b;
  logic       cin;
  assign a   = ui_in[3:0];
  assign b   = ui_in[7:4];
  assign cin = uio_in[0];

  // uio_in[7:1] has no function; fold it away so it cannot reach any output.
  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:1]};

  // Low block, rippled from cin.
  logic [1:0] s_lo;
  logic       c2;

  csa_rca #(.W(2)) u_lo (
    .a  (a[1:0]),
    .b  (b[1:0]),
    .ci (cin),
    .s  (s_lo),
    .co (c2)
  );

  // High block. Instance k assumes carry-in == k. The two are kept as
  // separate adders so that both results are ready before c2 settles.
  logic [NUM_SPEC-1:0][1:0] s_hi;
  logic [NUM_SPEC-1:0]      c_hi;

  genvar k;
  generate
    for (k = 0; k < NUM_SPEC; k++) begin : g_spec
      csa_rca #(.W(2)) u_hi (
        .a  (a[3:2]),
        .b  (b[3:2]),
        .ci ((k == 1) ? 1'b1 : 1'b0),
        .s  (s_hi[k]),
        .co (c_hi[k])
      );
    end
  endgenerate

  logic [3:0] s;
  logic       cout, v, z;
  logic [7:0] uo_nxt;

  assign s      = {(c2 ? s_hi[1] : s_hi[0]), s_lo};
  assign cout   = c2 ? c_hi[1] : c_hi[0];
  // Signed overflow: the operands have the same sign, but the sum has the other sign.
  assign v      = (a[3] == b[3]) && (s[3] != a[3]);
  assign z      = (s == 4'h0);
  assign uo_nxt = {c2, z, v, cout, s};

  logic [7:0] uo_q;
  always_ff @(posedge clk) begin
    if (!rst_n)   uo_q <= 8'h00;
    else if (ena) uo_q <= uo_nxt;
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_carry_select_adder_tt.sv
module tb_carry_select_adder_tt;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  carry_select_adder_tt dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Reference model. It uses plain integer arithmetic on the operand values.
  function automatic logic [7:0] model(input int a, input int b, input int ci);
    int sum, sa, sb, ss, lo;
    logic [7:0] r;
    sum = a + b + ci;
    sa  = (a >= 8) ? a - 16 : a;
    sb  = (b >= 8) ? b - 16 : b;
    ss  = sa + sb + ci;
    lo  = (a % 4) + (b % 4) + ci;
    r[3:0] = 4'(sum % 16);
    r[4]   = (sum >= 16);
    r[5]   = (ss > 7) || (ss < -8);
    r[6]   = ((sum % 16) == 0);
    r[7]   = (lo >= 4);
    return r;
  endfunction

  // Step one clock. Outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk("uio_out", uio_out, 8'h00);
    chk("uio_oe",  uio_oe,  8'h00);
  endtask

  task automatic drive(input int a, input int b, input int ci, input logic [6:0] junk);
    ui_in  = {4'(b), 4'(a)};
    uio_in = {junk, 1'(ci)};
  endtask

  logic [7:0] held;

  initial begin
    // Reset holds uo_out at zero even with ena=1 and live inputs.
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'hFF; uio_in = 8'h01;
    step(); step();
    chk("reset", uo_out, 8'h00);
    ena = 1'b0; rst_n = 1'b1;
    step();
    chk("ena0_after_reset", uo_out, 8'h00);

    // Directed cases.
    ena = 1'b1;
    drive(3, 4, 0, 7'h00);   step(); chk("3+4",     uo_out, 8'h07);
    drive(15, 1, 0, 7'h00);  step(); chk("15+1",    uo_out, 8'hD0);
    drive(7, 1, 0, 7'h00);   step(); chk("7+1",     uo_out, 8'hA8);
    drive(15, 15, 1, 7'h00); step(); chk("15+15+1", uo_out, 8'h9F);
    ena = 1'b0;
    drive(2, 9, 0, 7'h55);   step(); chk("hold",    uo_out, 8'h9F);
    step();                          chk("hold2",   uo_out, 8'h9F);

    // Exhaustive sweep. The unused uio bits carry random junk.
    ena = 1'b1;
    for (int ci = 0; ci < 2; ci++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          drive(a, b, ci, 7'($urandom));
          step();
          chk("sweep", uo_out, model(a, b, ci));
        end

    // Random traffic with random ena. The model holds the value when ena=0.
    held = uo_out;
    for (int i = 0; i < 300; i++) begin
      int a, b, ci;
      a = $urandom_range(15); b = $urandom_range(15); ci = $urandom_range(1);
      ena = 1'($urandom_range(1));
      drive(a, b, ci, 7'($urandom));
      if (ena) held = model(a, b, ci);
      step();
      chk("random", uo_out, held);
    end

    // Reset during operation discards the pending result.
    ena = 1'b1;
    drive(9, 9, 1, 7'h00); step(); chk("pre_rst", uo_out, model(9, 9, 1));
    drive(5, 6, 0, 7'h00); rst_n = 1'b0;
    step(); chk("mid_rst", uo_out, 8'h00);
    rst_n = 1'b1;
    step(); chk("post_rst", uo_out, model(5, 6, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
